// File: rtl/half3_sched.sv
// half3_sched: two-channel front end for the shared half3 half-band decimator.
// Buffers streams A and B, sequences the 4-phase frame and collects one output per frame.

module half3_sched_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // The extra pointer bit tells full from empty when the addresses coincide.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which words are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end
endmodule

module half3_sched #(
    parameter int DW     = 16,
    parameter int OW     = 17,
    parameter int FDEPTH = 4,
    parameter int LAT    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          clr_status,
    input  logic [DW-1:0] a_data,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [DW-1:0] b_data,
    input  logic          b_valid,
    output logic          b_ready,
    output logic [DW-1:0] f_a,
    output logic [DW-1:0] f_b,
    output logic          f_ab,
    input  logic [OW-1:0] f_d,
    output logic [OW-1:0] out_data,
    output logic          out_valid,
    output logic          a_underrun,
    output logic          b_underrun,
    output logic          busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int            CW    = $clog2(LAT + 1);
    localparam logic [CW-1:0] LAT_C = CW'(LAT);

    state_t        state;
    state_t        state_next;
    logic [1:0]    ph;
    logic [CW-1:0] fill;
    logic [CW-1:0] drain_cnt;

    logic          pop_slot;
    logic          take;
    logic          a_full;
    logic          a_empty;
    logic          b_full;
    logic          b_empty;
    logic [DW-1:0] a_word;
    logic [DW-1:0] b_word;

    assign a_ready  = !a_full;
    assign b_ready  = !b_full;
    assign pop_slot = (state == RUN) && ph[0];
    assign take     = (state != IDLE) && (ph == 2'd0) && (fill == LAT_C);
    assign f_ab     = ph[1];
    assign busy     = (state != IDLE);

    half3_sched_fifo #(.DW(DW), .DEPTH(FDEPTH)) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .push      (a_valid && !a_full),
        .push_data (a_data),
        .pop       (pop_slot && !a_empty),
        .pop_data  (a_word),
        .full      (a_full),
        .empty     (a_empty)
    );

    half3_sched_fifo #(.DW(DW), .DEPTH(FDEPTH)) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .push      (b_valid && !b_full),
        .push_data (b_data),
        .pop       (pop_slot && !b_empty),
        .pop_data  (b_word),
        .full      (b_full),
        .empty     (b_empty)
    );

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (run) state_next = RUN;
            RUN:     if (!run && (ph == 2'd3)) state_next = DRAIN;
            DRAIN:   if ((ph == 2'd0) && (drain_cnt == LAT_C)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ph        <= 2'd0;
            fill      <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_next;
            // Phase and fill both restart from zero for every streaming session.
            if ((state == IDLE) || (state_next == IDLE)) begin
                ph   <= 2'd0;
                fill <= '0;
            end else begin
                ph <= ph + 2'd1;
                if (fill != LAT_C) begin
                    fill <= fill + 1'b1;
                end
            end
            if (state != DRAIN) begin
                drain_cnt <= '0;
            end else if (drain_cnt != LAT_C) begin
                drain_cnt <= drain_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_a        <= '0;
            f_b        <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            a_underrun <= 1'b0;
            b_underrun <= 1'b0;
        end else begin
            // Zero-stuffing: only a pop slot with data puts a sample on the filter inputs.
            f_a <= (pop_slot && !a_empty) ? a_word : '0;
            f_b <= (pop_slot && !b_empty) ? b_word : '0;

            if (pop_slot && a_empty) begin
                a_underrun <= 1'b1;
            end else if (clr_status) begin
                a_underrun <= 1'b0;
            end
            if (pop_slot && b_empty) begin
                b_underrun <= 1'b1;
            end else if (clr_status) begin
                b_underrun <= 1'b0;
            end

            out_valid <= take;
            if (take) begin
                out_data <= f_d;
            end
        end
    end
endmodule

// File: tb/tb_half3_sched.sv
// Self-checking bench for half3_sched: directed scenarios plus randomised traffic
// against a frame-index reference model; f_d comes from an ideal LAT-cycle delay line.

module tb_half3_sched;
    localparam int DW     = 16;
    localparam int OW     = 17;
    localparam int FDEPTH = 4;
    localparam int LAT    = 10;
    localparam int VW     = 2 * DW + OW + 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic          clr_status;
    logic [DW-1:0] a_data;
    logic          a_valid;
    logic          a_ready;
    logic [DW-1:0] b_data;
    logic          b_valid;
    logic          b_ready;
    logic [DW-1:0] f_a;
    logic [DW-1:0] f_b;
    logic          f_ab;
    logic [OW-1:0] f_d;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          a_underrun;
    logic          b_underrun;
    logic          busy;

    half3_sched #(.DW(DW), .OW(OW), .FDEPTH(FDEPTH), .LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .clr_status (clr_status),
        .a_data     (a_data),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .b_data     (b_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .f_a        (f_a),
        .f_b        (f_b),
        .f_ab       (f_ab),
        .f_d        (f_d),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .a_underrun (a_underrun),
        .b_underrun (b_underrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: session-relative cycle index k, drain start index, sample queues.
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic [OW-1:0] fd_line[$];
    bit            m_act;
    int            m_k;
    int            m_dstart;
    logic [DW-1:0] e_fa;
    logic [DW-1:0] e_fb;
    logic          e_ov;
    logic [OW-1:0] e_od;
    logic          e_ua;
    logic          e_ub;

    function automatic int model_ph();
        return m_act ? (m_k % 4) : 0;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {(qa.size() < FDEPTH), (qb.size() < FDEPTH), m_act, (model_ph() >= 2),
                e_fa, e_fb, e_ov, e_od, e_ua, e_ub};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {a_ready, b_ready, busy, f_ab, f_a, f_b, out_valid, out_data, a_underrun, b_underrun};
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        fd_line.delete();
        for (int i = 0; i < LAT; i++) fd_line.push_back('0);
        m_act    = 1'b0;
        m_k      = 0;
        m_dstart = -1;
        e_fa     = '0;
        e_fb     = '0;
        e_ov     = 1'b0;
        e_od     = '0;
        e_ua     = 1'b0;
        e_ub     = 1'b0;
    endtask

    task automatic model_advance();
        int            ph;
        bit            running;
        bit            a_push;
        bit            b_push;
        bit            take;
        bit            ua_set;
        bit            ub_set;
        logic [DW-1:0] nfa;
        logic [DW-1:0] nfb;
        ph      = model_ph();
        running = m_act && (m_dstart < 0);
        a_push  = (a_valid === 1'b1) && (qa.size() < FDEPTH);
        b_push  = (b_valid === 1'b1) && (qb.size() < FDEPTH);
        nfa     = '0;
        nfb     = '0;
        ua_set  = 1'b0;
        ub_set  = 1'b0;
        if (running && (ph % 2 == 1)) begin
            if (qa.size() > 0) nfa = qa.pop_front(); else ua_set = 1'b1;
            if (qb.size() > 0) nfb = qb.pop_front(); else ub_set = 1'b1;
        end
        if (a_push) qa.push_back(a_data);
        if (b_push) qb.push_back(b_data);
        take = m_act && (ph == 0) && (m_k >= LAT);
        e_ov = take;
        if (take) e_od = f_d;
        if (ua_set) e_ua = 1'b1; else if (clr_status) e_ua = 1'b0;
        if (ub_set) e_ub = 1'b1; else if (clr_status) e_ub = 1'b0;
        e_fa = nfa;
        e_fb = nfb;
        if (!m_act) begin
            if (run) begin
                m_act    = 1'b1;
                m_k      = 0;
                m_dstart = -1;
            end
        end else begin
            if (m_dstart < 0) begin
                if (!run && (ph == 3)) m_dstart = m_k + 1;
            end else if ((ph == 0) && (m_k - m_dstart >= LAT)) begin
                m_act = 1'b0;
            end
            m_k++;
        end
    endtask

    // One clock: feed f_d from the ideal delay line, advance the model, move to edge+1.
    task automatic cycle();
        logic [OW-1:0] cur;
        cur = {e_fa[DW-1], e_fa} + {e_fb[DW-1], e_fb};
        f_d = fd_line[0];
        model_advance();
        fd_line.delete(0);
        fd_line.push_back(cur);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        run        = 1'b0;
        clr_status = 1'b0;
        a_valid    = 1'b0;
        b_valid    = 1'b0;
        a_data     = '0;
        b_data     = '0;
        f_d        = '0;
        model_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [VW-1:0] want;
        want = {2'b11, {(VW - 2){1'b0}}};
        #7;
        n_checks++;
        if (dut_vec() !== want) $display("FAIL reset_hold: got %h expected %h", dut_vec(), want);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        cycle();
        n_checks++;
        if (dut_vec() !== want) $display("FAIL reset_release: got %h expected %h", dut_vec(), want);
        else n_pass++;
    endtask

    task automatic test_stream();
        int fa_exp [9];
        int fb_exp [9];
        fa_exp = '{0, 0, 100, 0, 200, 0, 300, 0, 400};
        fb_exp = '{0, 0, -1, 0, -2, 0, -3, 0, -4};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1;
            b_valid = 1'b1;
            a_data  = DW'(100 * (i + 1));
            b_data  = DW'(-(i + 1));
            cycle();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        run     = 1'b1;
        cycle();
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if ({f_a, f_b, f_ab} !== {DW'(fa_exp[k]), DW'(fb_exp[k]), (k % 4 >= 2)})
                $display("FAIL stream_k%0d: got fa=%0d fb=%0d ab=%b expected fa=%0d fb=%0d ab=%b",
                         k, $signed(f_a), $signed(f_b), f_ab, fa_exp[k], fb_exp[k], (k % 4 >= 2));
            else n_pass++;
            cycle();
        end
        n_checks++;
        if ({a_underrun, b_underrun} !== 2'b00)
            $display("FAIL stream_no_underrun: got %b%b expected 00", a_underrun, b_underrun);
        else n_pass++;
        run = 1'b0;
        for (int c = 0; c < 60 && busy !== 1'b0; c++) cycle();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL stream_idle: got busy=%b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_data = DW'(11 + i);
            n_checks++;
            if (a_ready !== 1'b1) $display("FAIL bp_accept%0d: got a_ready=%b expected 1", i, a_ready);
            else n_pass++;
            cycle();
        end
        a_data = DW'(15);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (a_ready !== 1'b0) $display("FAIL bp_full%0d: got a_ready=%b expected 0", i, a_ready);
            else n_pass++;
            cycle();
        end
        run = 1'b1;
        cycle();
        for (int k = 0; k <= 10; k++) begin
            if (k < 2) begin
                n_checks++;
                if (a_ready !== 1'b0) $display("FAIL bp_hold_k%0d: got a_ready=%b expected 0", k, a_ready);
                else n_pass++;
            end
            if (k == 2) begin
                n_checks++;
                if (a_ready !== 1'b1) $display("FAIL bp_release: got a_ready=%b expected 1", a_ready);
                else n_pass++;
            end
            if (k == 10) begin
                n_checks++;
                if (f_a !== DW'(15)) $display("FAIL bp_fifth: got f_a=%0d expected 15", f_a);
                else n_pass++;
            end
            cycle();
            if (k == 2) a_valid = 1'b0;
        end
    endtask

    task automatic test_underrun();
        do_reset();
        a_valid = 1'b1;
        a_data  = DW'($urandom);
        cycle();
        cycle();
        run = 1'b1;
        cycle();
        cycle();
        cycle();
        n_checks++;
        if ({b_underrun, a_underrun, f_b} !== {1'b1, 1'b0, {DW{1'b0}}})
            $display("FAIL ur_set: got bu=%b au=%b f_b=%0d expected bu=1 au=0 f_b=0", b_underrun, a_underrun, f_b);
        else n_pass++;
        clr_status = 1'b1;
        cycle();
        clr_status = 1'b0;
        n_checks++;
        if (b_underrun !== 1'b0) $display("FAIL ur_clear: got %b expected 0", b_underrun);
        else n_pass++;
        clr_status = 1'b1;
        cycle();
        clr_status = 1'b0;
        n_checks++;
        if (b_underrun !== 1'b1) $display("FAIL ur_set_wins: got %b expected 1", b_underrun);
        else n_pass++;
    endtask

    task automatic test_drain();
        int strobes;
        int last;
        bit gap_bad;
        bit done;
        do_reset();
        a_valid = 1'b1;
        b_valid = 1'b1;
        run     = 1'b1;
        cycle();
        for (int k = 0; k < 13; k++) begin
            a_data = DW'($urandom);
            b_data = DW'($urandom);
            cycle();
        end
        run     = 1'b0;
        strobes = 0;
        last    = -1;
        gap_bad = 1'b0;
        done    = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL drain_c%0d: got %h expected %h", c, dut_vec(), exp_vec());
            else n_pass++;
            if (out_valid === 1'b1) begin
                if (last >= 0 && c - last != 4) gap_bad = 1'b1;
                last = c;
                strobes++;
            end
            done = (busy === 1'b0);
            if (!done) cycle();
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL drain_idle: got busy=%b expected 0", busy);
        else n_pass++;
        n_checks++;
        if (strobes < (LAT + 3) / 4 || gap_bad)
            $display("FAIL drain_strobes: got %0d strobes gap_bad=%b expected >=%0d spaced 4", strobes, gap_bad, (LAT + 3) / 4);
        else n_pass++;
    endtask

    task automatic test_abort();
        do_reset();
        a_valid = 1'b1;
        b_valid = 1'b1;
        repeat (4) cycle();
        run = 1'b1;
        repeat (7) begin
            a_data = DW'($urandom);
            b_data = DW'($urandom);
            cycle();
        end
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, f_ab, f_a, f_b, a_ready, b_ready} !== {2'b00, {(2 * DW){1'b0}}, 2'b11})
            $display("FAIL abort_immediate: got busy=%b ab=%b fa=%0d fb=%0d ar=%b br=%b expected 0 0 0 0 1 1",
                     busy, f_ab, f_a, f_b, a_ready, b_ready);
        else n_pass++;
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (3) cycle();
        n_checks++;
        if ({a_underrun, b_underrun, f_a} !== {2'b11, {DW{1'b0}}})
            $display("FAIL abort_discard: got au=%b bu=%b fa=%0d expected 1 1 0", a_underrun, b_underrun, f_a);
        else n_pass++;
    endtask

    task automatic test_datapath();
        logic [DW-1:0] sa[$];
        logic [DW-1:0] sb[$];
        logic [OW-1:0] got[$];
        logic [OW-1:0] want;
        int            ia;
        int            ib;
        bit            fire_a;
        bit            fire_b;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            sa.push_back((i % 8 == 0) ? DW'(1024) : DW'(0));
            sb.push_back(DW'($urandom));
        end
        ia      = 0;
        ib      = 0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = sa[0];
        b_data  = sb[0];
        for (int c = 0; c < 64; c++) begin
            if (c == 4) run = 1'b1;
            if (out_valid === 1'b1) got.push_back(out_data);
            fire_a = a_valid && a_ready;
            fire_b = b_valid && b_ready;
            cycle();
            if (fire_a) ia++;
            if (fire_b) ib++;
            a_valid = (ia < 40);
            b_valid = (ib < 40);
            a_data  = (ia < 40) ? sa[ia] : '0;
            b_data  = (ib < 40) ? sb[ib] : '0;
        end
        n_checks++;
        if (got.size() != 12) $display("FAIL dp_count: got %0d outputs expected 12", got.size());
        else n_pass++;
        for (int j = 0; j < 12 && j < got.size(); j++) begin
            want = {sa[2 * j][DW-1], sa[2 * j]} + {sb[2 * j][DW-1], sb[2 * j]};
            n_checks++;
            if (got[j] !== want) $display("FAIL dp_out%0d: got %h expected %h", j, got[j], want);
            else n_pass++;
        end
        n_checks++;
        if ({a_underrun, b_underrun} !== 2'b00)
            $display("FAIL dp_no_underrun: got %b%b expected 00", a_underrun, b_underrun);
        else n_pass++;
    endtask

    task automatic test_random();
        bit run_tgt;
        do_reset();
        run_tgt = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(11, 0) == 0) run_tgt = !run_tgt;
            run        = run_tgt;
            a_valid    = ($urandom_range(2, 0) != 0);
            b_valid    = ($urandom_range(1, 0) != 0);
            a_data     = DW'($urandom);
            b_data     = DW'($urandom);
            clr_status = ($urandom_range(19, 0) == 0);
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL rand_c%0d: got %h expected %h", i, dut_vec(), exp_vec());
            else n_pass++;
            cycle();
        end
    endtask

    initial begin
        rst        = 1'b1;
        run        = 1'b0;
        clr_status = 1'b0;
        a_valid    = 1'b0;
        b_valid    = 1'b0;
        a_data     = '0;
        b_data     = '0;
        f_d        = '0;
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_underrun();
        test_drain();
        test_abort();
        test_datapath();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
